// File: rtl/prog_loader.sv
// Program image loader: frames a {length, words, checksum} byte stream into
// 16-bit instruction words and writes them to consecutive RAM addresses.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_SIZE   = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oCpuHold,
  output logic                  oDone,
  output logic                  oError,
  output logic [ADDR_WIDTH:0]   oWordCount
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [7:0]      sum;
  logic [7:0]      hi_byte;
  logic [1:0]      len_hi;
  logic [CW-1:0]   len;
  logic            accept;
  logic [9:0]      len_full;
  logic [CW-1:0]   count_next;

  assign accept     = iByteValid && oByteReady;
  assign len_full   = {len_hi, iByte};
  assign count_next = oWordCount + CW'(1);

  // oByteReady is registered alongside state so it always mirrors the state being entered.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= S_IDLE;
      sum          <= '0;
      hi_byte      <= '0;
      len_hi       <= '0;
      len          <= '0;
      oByteReady   <= 1'b0;
      oWriteEnable <= 1'b0;
      oAddress     <= '0;
      oDataOut     <= '0;
      oCpuHold     <= 1'b1;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oWordCount   <= '0;
    end else begin
      oWriteEnable <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (iStart) begin
            state      <= S_LEN_HI;
            oByteReady <= 1'b1;
            sum        <= '0;
            oWordCount <= '0;
            oDone      <= 1'b0;
            oError     <= 1'b0;
            oCpuHold   <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            sum <= sum + iByte;
            if (iByte[7:2] != 6'd0) begin
              state      <= S_ERROR;
              oByteReady <= 1'b0;
              oError     <= 1'b1;
            end else begin
              len_hi <= iByte[1:0];
              state  <= S_LEN_LO;
            end
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            sum <= sum + iByte;
            len <= CW'(len_full);
            if (32'(len_full) > MEM_SIZE) begin
              state      <= S_ERROR;
              oByteReady <= 1'b0;
              oError     <= 1'b1;
            end else if (len_full == 10'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            sum     <= sum + iByte;
            hi_byte <= iByte;
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            sum          <= sum + iByte;
            oDataOut     <= DATA_WIDTH'({hi_byte, iByte});
            oAddress     <= oWordCount[ADDR_WIDTH-1:0];
            oWriteEnable <= 1'b1;
            oWordCount   <= count_next;
            state        <= (count_next == len) ? S_CHECK : S_DATA_HI;
          end
        end
        S_CHECK: begin
          if (accept) begin
            oByteReady <= 1'b0;
            if (iByte == sum) begin
              state    <= S_DONE;
              oDone    <= 1'b1;
              oCpuHold <= 1'b0;
            end else begin
              state  <= S_ERROR;
              oError <= 1'b1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          oByteReady <= 1'b0;
        end
      endcase
    end
  end

endmodule
